// File: rtl/scanner_array_ctrl.sv
// Multi-channel scanner controller: per-channel scan/transfer/flush FSMs with
// scan handoff to the next channel and round-robin arbitration of one transfer bus.
module scanner_array_ctrl #(
    parameter int N          = 2,
    parameter int PW         = 4,
    parameter int SCAN_LEN   = 10,
    parameter int HANDOFF_AT = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N-1:0]                         go_standby,
    input  logic [N-1:0]                         start_scan,
    input  logic [N-1:0]                         start_xfer,
    input  logic [N-1:0]                         flush,
    output logic [3*N-1:0]                       state,
    output logic [PW*N-1:0]                      prog,
    output logic                                 xfer_busy,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] xfer_owner,
    output logic [N-1:0]                         done
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_LOW   = 3'b000,
        ST_STBY  = 3'b001,
        ST_SCAN  = 3'b010,
        ST_IDLE  = 3'b011,
        ST_XFER  = 3'b100,
        ST_FLUSH = 3'b101
    } ch_state_e;

    logic            r_active;
    ch_state_e       r_state [N];
    logic [PW-1:0]   r_prog  [N];
    logic [N-1:0]    r_done;
    logic [OW-1:0]   r_ptr;

    ch_state_e       w_state_nxt [N];
    logic [PW-1:0]   w_prog_nxt  [N];
    logic [N-1:0]    w_done_nxt;
    logic [N-1:0]    w_handoff;
    logic [N-1:0]    w_grant;
    logic            w_gvalid;
    logic [OW-1:0]   w_ptr_nxt;
    logic            w_busy;
    logic [OW-1:0]   w_owner;

    // Channel g is woken by its predecessor (g-1) mod N reaching HANDOFF_AT.
    for (genvar g = 0; g < N; g++) begin : g_handoff
        localparam int P = (g + N - 1) % N;
        always_comb begin
            w_handoff[g] = (N > 1) && (r_state[P] == ST_SCAN) && (r_prog[P] == PW'(HANDOFF_AT));
        end
    end

    always_comb begin
        w_busy  = 1'b0;
        w_owner = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_state[i] == ST_XFER) begin
                w_busy  = 1'b1;
                w_owner = OW'(i);
            end
        end
    end

    // Round-robin search begins at r_ptr; only while the bus is idle.
    always_comb begin
        int unsigned idx;
        w_grant   = '0;
        w_gvalid  = 1'b0;
        w_ptr_nxt = r_ptr;
        idx       = 0;
        if (!w_busy) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = (32'(r_ptr) + k) % N;
                if (!w_gvalid && r_state[idx] == ST_IDLE && start_xfer[idx]) begin
                    w_gvalid     = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_ptr_nxt    = OW'((idx + 1) % N);
                end
            end
        end
    end

    always_comb begin
        w_done_nxt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_prog_nxt[i]  = r_prog[i];
            if (!r_active) begin
                w_state_nxt[i] = ST_LOW;
                w_prog_nxt[i]  = '0;
                if (start && i == 0) begin
                    w_state_nxt[i] = ST_SCAN;
                end
            end else begin
                case (r_state[i])
                    ST_LOW: begin
                        w_prog_nxt[i] = '0;
                        if (go_standby[i] || w_handoff[i]) begin
                            w_state_nxt[i] = ST_STBY;
                        end
                    end
                    ST_STBY: begin
                        if (start_scan[i]) begin
                            w_state_nxt[i] = ST_SCAN;
                            w_prog_nxt[i]  = '0;
                        end
                    end
                    ST_SCAN: begin
                        if (r_prog[i] == PW'(SCAN_LEN)) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else begin
                            w_prog_nxt[i] = r_prog[i] + 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        if (start_xfer[i]) begin
                            if (w_grant[i]) begin
                                w_state_nxt[i] = ST_XFER;
                            end
                        end else if (flush[i]) begin
                            w_state_nxt[i] = ST_FLUSH;
                        end
                    end
                    ST_XFER: begin
                        if (r_prog[i] == '0) begin
                            w_state_nxt[i] = ST_LOW;
                            w_done_nxt[i]  = 1'b1;
                        end else begin
                            w_prog_nxt[i] = r_prog[i] - 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_prog[i] == '0) begin
                            w_state_nxt[i] = ST_LOW;
                        end else if (r_prog[i] >= PW'(2)) begin
                            w_prog_nxt[i] = r_prog[i] - PW'(2);
                        end else begin
                            w_prog_nxt[i] = '0;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_LOW;
                        w_prog_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
            r_done   <= '0;
            r_ptr    <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_state[i] <= ST_LOW;
                r_prog[i]  <= '0;
            end
        end else begin
            r_active <= r_active | start;
            r_done   <= w_done_nxt;
            if (w_gvalid) begin
                r_ptr <= w_ptr_nxt;
            end
            for (int unsigned i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_prog[i]  <= w_prog_nxt[i];
            end
        end
    end

    always_comb begin
        state = '0;
        prog  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            state[3*i +: 3]   = r_state[i];
            prog[PW*i +: PW]  = r_prog[i];
        end
    end

    assign xfer_busy  = w_busy;
    assign xfer_owner = w_owner;
    assign done       = r_done;

endmodule
